// File: rtl/udp_hdr_insert_pkg.sv
// Shared types and field positions for the UDP/IP/Ethernet header inserter.
// Stream word layout: {occ[1:0], eof, sof, data[31:0]}.
package udp_hdr_insert_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam int OCC_MSB     = 35;
  localparam int EOF_BIT     = 33;
  localparam int SOF_BIT     = 32;
  localparam int CTL_INS_BIT = 16;

  localparam logic [7:0] ADDR_MASK = 8'hC0;

endpackage

// File: rtl/udp_hdr_ram.sv
// 64x32 header store: synchronous write, asynchronous read.
// Latency: write visible the cycle after the strobe; read is combinational.
// Backpressure: none, the write port is always accepted.
module udp_hdr_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [5:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [64];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/udp_hdr_insert_tx.sv
// Prepends a programmed header to each packet; control word is consumed. Length patch: UDP_HDR_INSERT_LEN_PATCH_EN.
// Latency: payload is combinational pass-through; header words stream one per cycle from the RAM.
// Backpressure: dst_rdy_i low freezes header index and state; payload ready follows dst_rdy_i directly.
module udp_hdr_insert_tx #(
  parameter int BASE      = 0,
  parameter int HDR_WORDS = 13,
  parameter int LEN_IDX   = 4,
  parameter int LEN_ADD   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [35:0] datain,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] dataout,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i
);

  import udp_hdr_insert_pkg::*;

`ifdef UDP_HDR_INSERT_LEN_PATCH_EN
  localparam bit PATCH_EN = 1'b1;
`else
  localparam bit PATCH_EN = 1'b0;
`endif

  localparam logic [5:0]  LAST_IDX = 6'(HDR_WORDS - 1);
  localparam logic [5:0]  PATCH_IDX = 6'(LEN_IDX);
  localparam logic [15:0] LEN_OFS  = 16'(LEN_ADD);
  localparam logic [7:0]  BASE_BLK = 8'(BASE) & ADDR_MASK;

  state_t      state, state_nxt;
  logic [5:0]  idx, idx_nxt;
  logic        eof_pending, eof_pending_nxt;
  logic        first_pending, first_pending_nxt;
  logic [15:0] len, len_nxt;

  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] hdr_word;

  assign ram_we = set_stb && ((set_addr & ADDR_MASK) == BASE_BLK);

  udp_hdr_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (set_addr[5:0]),
    .wdata (set_data),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  // Low half of the selected word carries the packet length when patching is built in.
  always_comb begin
    hdr_word = ram_rdata;
    if (PATCH_EN && (idx == PATCH_IDX)) begin
      hdr_word[15:0] = len + LEN_OFS;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      eof_pending   <= 1'b0;
      first_pending <= 1'b0;
      len           <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      eof_pending   <= eof_pending_nxt;
      first_pending <= first_pending_nxt;
      len           <= len_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    idx_nxt           = idx;
    eof_pending_nxt   = eof_pending;
    first_pending_nxt = first_pending;
    len_nxt           = len;
    dst_rdy_o         = 1'b0;
    src_rdy_o         = 1'b0;
    dataout           = '0;

    case (state)
      IDLE: begin
        dst_rdy_o = 1'b1;
        // Words without sof here are stray tails and are dropped.
        if (src_rdy_i && datain[SOF_BIT]) begin
          len_nxt = datain[15:0];
          if (datain[CTL_INS_BIT]) begin
            state_nxt       = HDR;
            idx_nxt         = '0;
            eof_pending_nxt = datain[EOF_BIT];
          end else if (!datain[EOF_BIT]) begin
            state_nxt         = PAYLOAD;
            first_pending_nxt = 1'b1;
          end
        end
      end

      HDR: begin
        src_rdy_o = 1'b1;
        dataout   = {2'b00, eof_pending && (idx == LAST_IDX), idx == 6'd0, hdr_word};
        if (dst_rdy_i) begin
          if (idx == LAST_IDX) begin
            idx_nxt           = '0;
            eof_pending_nxt   = 1'b0;
            first_pending_nxt = 1'b0;
            state_nxt         = eof_pending ? IDLE : PAYLOAD;
          end else begin
            idx_nxt = idx + 6'd1;
          end
        end
      end

      PAYLOAD: begin
        src_rdy_o = src_rdy_i;
        dst_rdy_o = dst_rdy_i;
        dataout   = {datain[OCC_MSB:EOF_BIT], first_pending, datain[31:0]};
        if (src_rdy_i && dst_rdy_i) begin
          first_pending_nxt = 1'b0;
          if (datain[EOF_BIT]) begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (clear) begin
      state_nxt         = IDLE;
      idx_nxt           = '0;
      eof_pending_nxt   = 1'b0;
      first_pending_nxt = 1'b0;
      len_nxt           = '0;
    end
  end

endmodule

// File: tb/tb_udp_hdr_insert_tx.sv
// Randomized bench for udp_hdr_insert_tx: packets are expanded into expected output
// words by a list-level model and checked in order at the output handshake.
module tb_udp_hdr_insert_tx;

  localparam int HDR_WORDS = 13;
  localparam int LEN_IDX   = 4;
  localparam int LEN_ADD   = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [35:0] datain;
  logic        src_rdy_i;
  logic        dst_rdy_o;
  logic [35:0] dataout;
  logic        src_rdy_o;
  logic        dst_rdy_i;

  always #5 clk = ~clk;

  udp_hdr_insert_tx #(
    .BASE      (0),
    .HDR_WORDS (HDR_WORDS),
    .LEN_IDX   (LEN_IDX),
    .LEN_ADD   (LEN_ADD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .datain    (datain),
    .src_rdy_i (src_rdy_i),
    .dst_rdy_o (dst_rdy_o),
    .dataout   (dataout),
    .src_rdy_o (src_rdy_o),
    .dst_rdy_i (dst_rdy_i)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram_m [64];
  logic [35:0] in_q  [$];
  logic [35:0] exp_q [$];
  int          valid_pct;
  int          ready_pct;
  bit          toggle_rdy;

  function automatic logic [31:0] hdr_model(input int i, input logic [15:0] len);
    logic [31:0] w;
    w = ram_m[i];
`ifdef UDP_HDR_INSERT_LEN_PATCH_EN
    if (i == LEN_IDX) w[15:0] = len + 16'(LEN_ADD);
`endif
    return w;
  endfunction

  task automatic write_hdr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk); #1;
    set_stb  = 1'b0;
    if (a[7:6] == 2'b00) ram_m[a[5:0]] = d;
  endtask

  // Expands one packet into input words and the words the block must emit for it.
  task automatic queue_packet(input bit ins, input logic [15:0] len, input int n,
                              input logic [31:0] base, input logic [31:0] step,
                              input logic [1:0] last_occ);
    logic [31:0] ctl;
    logic [31:0] d;
    logic [14:0] junk;
    junk = 15'($urandom);
    ctl  = {junk, ins, len};
    in_q.push_back({2'b00, n == 0, 1'b1, ctl});
    if (ins) begin
      for (int i = 0; i < HDR_WORDS; i++)
        exp_q.push_back({2'b00, (n == 0) && (i == HDR_WORDS - 1), i == 0, hdr_model(i, len)});
    end
    d = base;
    for (int k = 0; k < n; k++) begin
      logic       last;
      logic [1:0] occ;
      last = (k == n - 1);
      occ  = last ? last_occ : 2'b00;
      in_q.push_back({occ, last, 1'b0, d});
      exp_q.push_back({occ, last, (k == 0) && !ins, d});
      d = d + step;
    end
  endtask

  task automatic run_traffic(input int budget);
    bit          done = 1'b0;
    int          idle = 0;
    bit          prev_stall = 1'b0;
    logic [35:0] prev_out = '0;
    logic [35:0] exp;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      if (in_q.size() > 0 && $urandom_range(99) < valid_pct) begin
        src_rdy_i = 1'b1;
        datain    = in_q[0];
      end else begin
        src_rdy_i = 1'b0;
        datain    = '0;
      end
      if (toggle_rdy) dst_rdy_i = ~dst_rdy_i;
      else            dst_rdy_i = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (prev_stall && src_rdy_o) begin
        n_vec++;
        if (dataout !== prev_out) begin
          n_err++;
          $display("FAIL stall_hold: dataout=%h required %h", dataout, prev_out);
        end
      end
      if (src_rdy_o && dst_rdy_i) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_word: dataout=%h required no output", dataout);
        end else begin
          exp = exp_q.pop_front();
          if (dataout !== exp) begin
            n_err++;
            $display("FAIL out_word: dataout=%h required %h", dataout, exp);
          end
        end
      end
      if (src_rdy_i && dst_rdy_o) void'(in_q.pop_front());
      prev_stall = src_rdy_o && !dst_rdy_i;
      prev_out   = dataout;
      @(posedge clk); #1;
      if (in_q.size() == 0 && exp_q.size() == 0) idle++;
      else idle = 0;
      if (idle >= 4) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: %0d inputs and %0d outputs left, required 0 and 0",
               in_q.size(), exp_q.size());
    end
    in_q.delete();
    exp_q.delete();
    src_rdy_i = 1'b0;
  endtask

  task automatic start_header();
    dst_rdy_i = 1'b1;
    src_rdy_i = 1'b1;
    datain    = {2'b00, 1'b0, 1'b1, 32'h0001_000C};
    @(posedge clk); #1;
    src_rdy_i = 1'b0;
    datain    = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (src_rdy_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_hdr_vld: src_rdy_o=%b required 1", src_rdy_o);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    clear     = 1'b0;
    set_stb   = 1'b0;
    set_addr  = '0;
    set_data  = '0;
    datain    = '0;
    src_rdy_i = 1'b0;
    dst_rdy_i = 1'b0;
    #12;
    n_vec++;
    if (src_rdy_o !== 1'b0) begin n_err++; $display("FAIL rst_src_rdy: %b required 0", src_rdy_o); end
    n_vec++;
    if (dst_rdy_o !== 1'b1) begin n_err++; $display("FAIL rst_dst_rdy: %b required 1", dst_rdy_o); end
    n_vec++;
    if (dataout !== 36'h0) begin n_err++; $display("FAIL rst_dataout: %h required 0", dataout); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_hdr_insert();
    logic [31:0] hdr [13];
    hdr = '{32'h89ABCDEF, 32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888,
            32'h9999AAAA, 32'hBBBBCCCC, 32'hDDDDEEEE, 32'h0F0F0011, 32'h00220033,
            32'h00440055, 32'h00660077, 32'h00880099};
    for (int i = 0; i < 13; i++) write_hdr(8'(i), hdr[i]);
    write_hdr(8'h44, 32'hDEADBEEF);
    valid_pct  = 100;
    ready_pct  = 100;
    toggle_rdy = 1'b0;
    queue_packet(1'b1, 16'h000C, 4, 32'hA0B0C0D0, 32'h01010101, 2'd0);
    run_traffic(200);
  endtask

  task automatic test_no_insert();
    queue_packet(1'b0, 16'h000C, 4, 32'hA0B0C0D0, 32'h01010101, 2'd0);
    run_traffic(200);
  endtask

  task automatic test_backpressure();
    toggle_rdy = 1'b1;
    valid_pct  = 100;
    queue_packet(1'b1, 16'h000F, 4, $urandom, $urandom, 2'd3);
    queue_packet(1'b0, 16'h0007, 2, $urandom, $urandom, 2'd3);
    run_traffic(400);
    toggle_rdy = 1'b0;
  endtask

  task automatic test_ctl_only();
    valid_pct = 100;
    ready_pct = 100;
    queue_packet(1'b1, 16'h0000, 0, 32'h0, 32'h0, 2'd0);
    queue_packet(1'b0, 16'h0000, 0, 32'h0, 32'h0, 2'd0);
    queue_packet(1'b1, 16'h0008, 2, 32'hC0DE0000, 32'h1, 2'd0);
    run_traffic(300);
  endtask

  task automatic test_random();
    valid_pct = 70;
    ready_pct = 60;
    for (int p = 0; p < 20; p++) begin
      if ($urandom_range(3) == 0) in_q.push_back({2'b00, 1'($urandom), 1'b0, 32'($urandom)});
      queue_packet(1'($urandom), 16'($urandom), $urandom_range(6), $urandom, $urandom,
                   2'($urandom));
    end
    run_traffic(4000);
  endtask

  task automatic test_clear_mid_header();
    start_header();
    clear = 1'b1;
    #1;
    n_vec++;
    if (src_rdy_o !== 1'b1) begin n_err++; $display("FAIL clr_sync: src_rdy_o=%b required 1", src_rdy_o); end
    @(posedge clk); #1;
    clear = 1'b0;
    n_vec++;
    if (src_rdy_o !== 1'b0) begin n_err++; $display("FAIL clr_vld: src_rdy_o=%b required 0", src_rdy_o); end
    n_vec++;
    if (dst_rdy_o !== 1'b1) begin n_err++; $display("FAIL clr_rdy: dst_rdy_o=%b required 1", dst_rdy_o); end
    valid_pct = 100;
    ready_pct = 100;
    queue_packet(1'b1, 16'h0010, 2, $urandom, $urandom, 2'd1);
    run_traffic(200);
  endtask

  task automatic test_reset_mid_header();
    start_header();
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (src_rdy_o !== 1'b0) begin n_err++; $display("FAIL arst_vld: src_rdy_o=%b required 0", src_rdy_o); end
    n_vec++;
    if (dataout !== 36'h0) begin n_err++; $display("FAIL arst_data: dataout=%h required 0", dataout); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    valid_pct = 100;
    ready_pct = 80;
    queue_packet(1'b1, 16'h0004, 1, $urandom, $urandom, 2'd2);
    run_traffic(200);
  endtask

  initial begin
    test_reset();
    test_hdr_insert();
    test_no_insert();
    test_backpressure();
    test_ctl_only();
    test_random();
    test_clear_mid_header();
    test_reset_mid_header();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
